uart_bus_master: RTL and testbench
==================================

UART_BUS_MASTER -- requirements
Module: uart_bus_master

Interface
REQ-001 SHALL have parameter INTERBYTE_TIMEOUT, default 2_500_000, meaning idle clk cycles between command bytes before the parser aborts.
REQ-002 SHALL have parameter BUS_TIMEOUT, default 1024, meaning maximum clk cycles mem_valid stays high without mem_ready.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_received  input  1  one-cycle strobe: rx_byte valid.
REQ-006 SHALL have port rx_byte  input  8  byte from UART core.
REQ-007 SHALL have port tx_trigger  output  1  one-cycle strobe: start sending tx_byte.
REQ-008 SHALL have port tx_byte  output  8  byte to UART core; held stable from trigger until tx_busy falls.
REQ-009 SHALL have port tx_busy  input  1  UART core transmitting.
REQ-010 SHALL have ports mem_valid out 1, mem_addr out 32, mem_wdata out 32, mem_wstrb out 4, mem_ready in 1, mem_rdata in 32: bus initiator.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 Command 'W' (0x57) + 4 address bytes + 4 data bytes, MSB first, SHALL issue one bus write, wstrb 4'b1111, then reply 'K' (0x4B).
REQ-013 Command 'R' (0x52) + 4 address bytes, MSB first, SHALL issue one bus read, wstrb 4'b0000, then reply mem_rdata as 4 bytes, MSB first.
REQ-014 Any other first byte SHALL produce reply '?' (0x3F), no bus access.
REQ-015 States: IDLE, ADDR, DATA, BUS, RESP, TXWAIT; IDLE->ADDR on 'W'/'R', IDLE->RESP on unknown byte; ADDR->DATA ('W') or BUS ('R') after 4th byte; DATA->BUS after 4th byte.
REQ-016 BUS: mem_valid, mem_addr, mem_wdata and mem_wstrb SHALL be asserted from the cycle after entry; they SHALL be stable until and including the cycle mem_ready=1; mem_valid SHALL drop the next cycle.
REQ-017 mem_rdata SHALL be captured in the cycle mem_valid=1 and mem_ready=1.
REQ-018 BUS SHALL abort after BUS_TIMEOUT cycles without mem_ready: mem_valid drops, reply 'E' (0x45).
REQ-019 RESP SHALL pulse tx_trigger only while tx_busy=0, then enter TXWAIT.
REQ-020 TXWAIT SHALL ignore tx_busy in its first cycle, then wait for tx_busy=0; then go to RESP if bytes remain, else IDLE.
REQ-021 In ADDR/DATA, an inter-byte gap of INTERBYTE_TIMEOUT cycles SHALL return to IDLE silently, discarding the partial command.
REQ-022 The timeout counter SHALL restart on every rx_received.
REQ-023 rx_received in BUS, RESP or TXWAIT SHALL be dropped; no queueing.
REQ-024 Byte counter SHALL be 2 bits, wrapping 3->0 at each field end.
REQ-025 Address SHALL be shifted in as addr <= {addr[23:0], rx_byte}; data likewise.
REQ-026 Address SHALL be passed unaligned; the bus decodes it.

Reset
REQ-027 On reset_n=0 at a clk edge: state IDLE; mem_valid=0, tx_trigger=0, busy=0.
REQ-028 On reset: mem_addr, mem_wdata, tx_byte = 0; mem_wstrb = 4'b0000; counters = 0.
REQ-029 Reset mid-transfer SHALL drop mem_valid on the next edge with no reply.

Structure
REQ-030 Shared package uart_bus_pkg SHALL hold: the state enum; the CMD_WRITE, CMD_READ, RSP_OK, RSP_ERR, RSP_BAD byte constants.
REQ-031 Sub-module timeout_counter SHALL be instantiated twice, once for inter-byte and once for bus timeouts, with ports clear, enable, expired and parameter LIMIT.

Verification
REQ-032 Rx 57 40 00 00 10 DE AD BE EF, mem_ready after 3 cycles -> one write, addr 0x40000010, wdata 0xDEADBEEF, wstrb 1111; tx 4B.
REQ-033 Rx 52 F0 00 10 00, mem_rdata 0x000000A5 with immediate ready -> wstrb 0000; tx 00 00 00 A5 in order, each tx_trigger only while tx_busy=0.
REQ-034 Rx 52 + address, mem_ready never asserted -> mem_valid high exactly BUS_TIMEOUT cycles; tx 45; busy=0 afterwards.
REQ-035 Rx 57 00 00 then silence for INTERBYTE_TIMEOUT -> no bus access, no tx; next 52 00 00 00 00 parsed fresh.
REQ-036 Rx 0x00 -> tx 3F; bytes received during the reply are dropped.
REQ-037 reset_n low mid-BUS -> mem_valid=0 next cycle; all outputs at reset values.

Source files
------------

// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART-to-bus command bridge: FSM state encoding
// and the command/response byte values seen on the serial link.
package uart_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_DATA   = 3'd2,
        ST_BUS    = 3'd3,
        ST_RESP   = 3'd4,
        ST_TXWAIT = 3'd5
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;
    localparam logic [7:0] RSP_BAD   = 8'h3F;

endpackage

// File: rtl/uart_bus_master_timeout_counter.sv
// Counts consecutive enabled cycles; expired is high during the LIMIT-th one.
// The count restarts whenever clear is high or enable is low.
module timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = enable && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Parses 'W'/'R' commands arriving byte-wise from a UART core, runs one bus
// transfer per command and streams the reply bytes back through the UART.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int INTERBYTE_TIMEOUT = 2_500_000,
    parameter int BUS_TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_received,
    input  logic [7:0]  rx_byte,
    output logic        tx_trigger,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output state_t      dbg_state_o
);

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        is_write_q, is_write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] resp_q, resp_d;
    logic        txw_first_q, txw_first_d;

    logic ib_enable, ib_expired;
    logic bus_enable, bus_expired;

    assign ib_enable  = (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign bus_enable = mem_valid_q && !mem_ready;

    timeout_counter #(.LIMIT(INTERBYTE_TIMEOUT)) u_ib_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (rx_received),
        .enable  (ib_enable),
        .expired (ib_expired)
    );

    timeout_counter #(.LIMIT(BUS_TIMEOUT)) u_bus_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != ST_BUS),
        .enable  (bus_enable),
        .expired (bus_expired)
    );

    // Reply bytes leave from the top of resp_q; byte_cnt_q counts the ones still queued behind it.
    assign tx_byte     = resp_q[31:24];
    assign tx_trigger  = (state_q == ST_RESP) && !tx_busy;
    assign busy        = (state_q != ST_IDLE);
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = data_q;
    assign mem_wstrb   = wstrb_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wstrb_d     = wstrb_q;
        mem_valid_d = mem_valid_q;
        resp_d      = resp_q;
        txw_first_d = txw_first_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_received) begin
                    byte_cnt_d = 2'd0;
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                        is_write_d = (rx_byte == CMD_WRITE);
                        state_d    = ST_ADDR;
                    end else begin
                        resp_d  = {RSP_BAD, 24'h0};
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (rx_received) begin
                    addr_d     = {addr_q[23:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = is_write_q ? ST_DATA : ST_BUS;
                    end
                end else if (ib_expired) begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (rx_received) begin
                    data_d     = {data_q[23:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_BUS;
                    end
                end else if (ib_expired) begin
                    byte_cnt_d = 2'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (!mem_valid_q) begin
                    mem_valid_d = 1'b1;
                    wstrb_d     = is_write_q ? 4'b1111 : 4'b0000;
                end else if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    resp_d      = is_write_q ? {RSP_OK, 24'h0} : mem_rdata;
                    byte_cnt_d  = is_write_q ? 2'd0 : 2'd3;
                    state_d     = ST_RESP;
                end else if (bus_expired) begin
                    mem_valid_d = 1'b0;
                    resp_d      = {RSP_ERR, 24'h0};
                    byte_cnt_d  = 2'd0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!tx_busy) begin
                    txw_first_d = 1'b1;
                    state_d     = ST_TXWAIT;
                end
            end
            ST_TXWAIT: begin
                txw_first_d = 1'b0;
                // The UART core raises tx_busy one cycle after the trigger, so the first cycle is blind.
                if (!txw_first_q && !tx_busy) begin
                    if (byte_cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q - 2'd1;
                        resp_d     = {resp_q[23:0], 8'h00};
                        state_d    = ST_RESP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 2'd0;
            is_write_q  <= 1'b0;
            addr_q      <= 32'h0;
            data_q      <= 32'h0;
            wstrb_q     <= 4'b0000;
            mem_valid_q <= 1'b0;
            resp_q      <= 32'h0;
            txw_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wstrb_q     <= wstrb_d;
            mem_valid_q <= mem_valid_d;
            resp_q      <= resp_d;
            txw_first_q <= txw_first_d;
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: UART and bus responders are modelled
// here, every reply byte is checked against a hand-built expected queue.
module tb_uart_bus_master;
    import uart_bus_pkg::*;

    localparam int IB_TO  = 40;
    localparam int BUS_TO = 16;

    logic        clk;
    logic        reset_n;
    logic        rx_received;
    logic [7:0]  rx_byte;
    logic        tx_trigger;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    state_t      dbg_state;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    int trig_busy   = 0;
    int tx_unstable = 0;
    int valid_cycles = 0;
    int hs_count     = 0;
    int bus_unstable = 0;

    uart_bus_master #(
        .INTERBYTE_TIMEOUT (IB_TO),
        .BUS_TIMEOUT       (BUS_TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_received (rx_received),
        .rx_byte     (rx_byte),
        .tx_trigger  (tx_trigger),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART core model: busy for several cycles after each trigger
    initial begin
        logic [7:0] b;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx_trigger === 1'b1) begin
                b = tx_byte;
                tx_log.push_back(b);
                if (tx_busy !== 1'b0) trig_busy++;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (tx_byte !== b) tx_unstable++;
                    if (tx_trigger !== 1'b0) trig_busy++;
                end
                @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Bus monitor: valid-high cycles, handshakes, request stability
    initial begin
        logic        pv;
        logic [31:0] pa, pd;
        logic [3:0]  ps;
        pv = 1'b0; pa = '0; pd = '0; ps = '0;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                valid_cycles++;
                if (pv && (mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== ps)) bus_unstable++;
                if (mem_ready === 1'b1) hs_count++;
            end
            pv = (mem_valid === 1'b1) && (mem_ready !== 1'b1);
            pa = mem_addr; pd = mem_wdata; ps = mem_wstrb;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte     = b;
        rx_received = 1'b1;
        tick();
        rx_received = 1'b0;
        repeat (2) tick();
    endtask

    task automatic send_bytes(input logic [71:0] v, input int n);
        for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_tx(input string tag);
        check({tag, "_txcount"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
            check({tag, "_txbyte"}, tx_log[i], exp_q[i]);
        end
    endtask

    task automatic serve_bus(input string tag, input int delay, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_wstrb);
        int n = 0;
        while (mem_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_req"}, mem_valid, 1'b1);
        check({tag, "_addr"}, mem_addr, exp_addr);
        if (exp_wstrb == 4'b1111) check({tag, "_wdata"}, mem_wdata, exp_wdata);
        check({tag, "_wstrb"}, mem_wstrb, exp_wstrb);
        repeat (delay) begin
            tick();
            check({tag, "_hold"}, mem_valid, 1'b1);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        check({tag, "_drop"}, mem_valid, 1'b0);
    endtask

    initial begin
        int base_valid;
        int base_hs;
        reset_n     = 1'b0;
        rx_received = 1'b0;
        rx_byte     = 8'h00;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;

        // Reset values
        repeat (3) tick();
        check("rst_valid", mem_valid, 1'b0);
        check("rst_trigger", tx_trigger, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wstrb", mem_wstrb, 4'b0000);
        check("rst_txbyte", tx_byte, 8'h00);
        reset_n = 1'b1;
        tick();

        // Write with ready after 3 cycles
        tx_log.delete();
        exp_q = '{8'h4B};
        base_hs = hs_count;
        send_bytes(72'h57_40_00_00_10_DE_AD_BE_EF, 9);
        serve_bus("wr", 3, 32'h0, 32'h4000_0010, 32'hDEAD_BEEF, 4'b1111);
        wait_idle("wr");
        check_tx("wr");
        check("wr_hs", hs_count - base_hs, 1);

        // Read with immediate ready
        tx_log.delete();
        exp_q = '{8'h00, 8'h00, 8'h00, 8'hA5};
        send_bytes(72'h52_F0_00_10_00, 5);
        serve_bus("rd", 0, 32'h0000_00A5, 32'hF000_1000, 32'h0, 4'b0000);
        wait_idle("rd");
        check_tx("rd");

        // Read with no ready: bus timeout
        tx_log.delete();
        exp_q = '{8'h45};
        base_valid = valid_cycles;
        base_hs    = hs_count;
        send_bytes(72'h52_12_34_56_78, 5);
        wait_idle("bto");
        check("bto_valid_cycles", valid_cycles - base_valid, BUS_TO);
        check("bto_hs", hs_count - base_hs, 0);
        check("bto_valid_low", mem_valid, 1'b0);
        check_tx("bto");

        // Partial write then silence
        tx_log.delete();
        exp_q.delete();
        base_valid = valid_cycles;
        send_bytes(72'h57_00_00, 3);
        repeat (30) tick();
        check("ib_pending", busy, 1'b1);
        repeat (30) tick();
        check("ib_abort", busy, 1'b0);
        check("ib_novalid", valid_cycles - base_valid, 0);
        check_tx("ib");

        // Fresh read after the abort
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(72'h52_00_00_00_00, 5);
        serve_bus("fresh", 1, 32'h1122_3344, 32'h0000_0000, 32'h0, 4'b0000);
        wait_idle("fresh");
        check_tx("fresh");

        // Unknown command; 'W' arriving during the reply is dropped
        tx_log.delete();
        exp_q = '{8'h3F};
        base_valid = valid_cycles;
        send_byte(8'h00);
        send_byte(8'h57);
        wait_idle("bad");
        repeat (5) tick();
        check("bad_still_idle", busy, 1'b0);
        check("bad_novalid", valid_cycles - base_valid, 0);
        check_tx("bad");

        // Reset while a bus request is outstanding
        tx_log.delete();
        send_bytes(72'h57_11_22_33_44_55_66_77_88, 9);
        begin
            int n = 0;
            while (mem_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
        end
        check("rb_req", mem_valid, 1'b1);
        reset_n = 1'b0;
        tick();
        check("rb_valid", mem_valid, 1'b0);
        check("rb_busy", busy, 1'b0);
        check("rb_trigger", tx_trigger, 1'b0);
        check("rb_addr", mem_addr, 32'h0);
        check("rb_wdata", mem_wdata, 32'h0);
        check("rb_wstrb", mem_wstrb, 4'b0000);
        check("rb_txbyte", tx_byte, 8'h00);
        reset_n = 1'b1;
        repeat (20) tick();
        check("rb_notx", tx_log.size(), 0);
        check("rb_idle", busy, 1'b0);

        // Whole-run protocol checks
        check("trigger_while_busy", trig_busy, 0);
        check("tx_byte_stable", tx_unstable, 0);
        check("bus_req_stable", bus_unstable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
